// File: rtl/vector_wb_arbiter.sv
// Two-requester round-robin write arbiter for a bank of R vector registers.
// Also runs a sequential clear of all R registers, one register per cycle.
module vector_wb_arbiter #(
    parameter  int I  = 2,
    parameter  int L  = 4,
    parameter  int R  = 8,
    localparam int AW = (R > 1) ? $clog2(R) : 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [1:0]           Req_Valid,
    input  logic [AW-1:0]        Req_Addr0,
    input  logic [AW-1:0]        Req_Addr1,
    input  logic [I-1:0][L-1:0]  Req_Data0,
    input  logic [I-1:0][L-1:0]  Req_Data1,
    output logic [1:0]           Req_Ready,
    input  logic                 Clear_Req,
    output logic                 Clear_Busy,
    output logic [R-1:0]         Wr_En,
    output logic [I-1:0][L-1:0]  Wr_Data,
    output logic [AW-1:0]        Wr_Addr
);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t               state_q, state_d;
    logic                 ptr_q, ptr_d;      // index of the requester granted last
    logic [AW-1:0]        cnt_q, cnt_d;
    logic [R-1:0]         wr_en_q, wr_en_d;
    logic [AW-1:0]        wr_addr_q, wr_addr_d;
    logic [I-1:0][L-1:0]  wr_data_q, wr_data_d;
    logic                 busy_q, busy_d;
    logic [1:0]           ready;
    logic [AW-1:0]        sel_addr;
    logic [I-1:0][L-1:0]  sel_data;

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        ready = 2'b00;
        if (RST && state_q == S_IDLE && !Clear_Req) begin
            unique case (Req_Valid)
                2'b01:   ready = 2'b01;
                2'b10:   ready = 2'b10;
                2'b11:   ready = ptr_q ? 2'b01 : 2'b10;
                default: ready = 2'b00;
            endcase
        end
    end

    assign sel_addr = ready[1] ? Req_Addr1 : Req_Addr0;
    assign sel_data = ready[1] ? Req_Data1 : Req_Data0;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        wr_en_d   = '0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (Clear_Req) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end else if (|ready) begin
                    ptr_d     = ready[1];
                    wr_addr_d = sel_addr;
                    wr_data_d = sel_data;
                    // An address >= R shifts the one-hot bit out of range, dropping the write.
                    wr_en_d   = R'(1) << sel_addr;
                end
            end
            S_CLEAR: begin
                wr_en_d   = R'(1) << cnt_q;
                wr_addr_d = cnt_q;
                wr_data_d = '0;
                if (cnt_q == AW'(R - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_CLEAR);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            ptr_q     <= 1'b1;
            cnt_q     <= '0;
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    assign Req_Ready  = ready;
    assign Clear_Busy = busy_q;
    assign Wr_En      = wr_en_q;
    assign Wr_Addr    = wr_addr_q;
    assign Wr_Data    = wr_data_q;

endmodule

// File: doc/vector_wb_arbiter.md
VECTOR_WB_ARBITER -- requirements
Module: vector_wb_arbiter

Interface
REQ-001 The block SHALL have parameter I, default 2, giving the number of elements per vector.
REQ-002 The block SHALL have parameter L, default 4, giving the bits per element.
REQ-003 The block SHALL have parameter R, default 8, giving the number of vector registers served; AW = $clog2(R).
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on posedge.
REQ-005 The block SHALL have port RST, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port Req_Valid, input, [1:0]: write request valid, one bit per requester k=0,1.
REQ-007 The block SHALL have ports Req_Addr0 and Req_Addr1, input, [AW-1:0]: target register of each requester.
REQ-008 The block SHALL have ports Req_Data0 and Req_Data1, input, [I-1:0][L-1:0]: vector data of each requester.
REQ-009 The block SHALL have port Req_Ready, output, [1:0]: grant per requester (combinational).
REQ-010 The block SHALL have port Clear_Req, input, 1 bit: request to zero all R registers.
REQ-011 The block SHALL have port Clear_Busy, output, 1 bit: clear sequence in progress.
REQ-012 The block SHALL have port Wr_En, output, [R-1:0]: one-hot (or zero) enable for the per-register EN inputs.
REQ-013 The block SHALL have port Wr_Data, output, [I-1:0][L-1:0]: shared Data_In for all registers.
REQ-014 The block SHALL have port Wr_Addr, output, [AW-1:0]: index of the register being written.

Function
REQ-015 The block SHALL implement FSM states IDLE and CLEAR.
REQ-016 In IDLE, a transfer on requester k SHALL occur in a cycle where Req_Valid[k]=1 and Req_Ready[k]=1.
REQ-017 At most one Req_Ready bit SHALL be high per cycle; Req_Ready[k] SHALL never be high while Req_Valid[k]=0.
REQ-018 If exactly one requester is valid in IDLE with Clear_Req=0, that requester SHALL be granted.
REQ-019 If both requesters are valid, the one not granted most recently SHALL be granted (round-robin); the last-grant pointer SHALL update only on a transfer.
REQ-020 Wr_Data, Wr_Addr and Wr_En SHALL be registered: a transfer in cycle n SHALL produce Wr_En=1<<addr, Wr_Addr=addr and Wr_Data=data in cycle n+1 only (latency 1, one-cycle pulse).
REQ-021 In any cycle with no transfer and no clear step, Wr_En SHALL be 0 on the following cycle; Wr_Data and Wr_Addr SHALL hold their previous values.
REQ-022 A transfer with addr >= R (non-power-of-2 R) SHALL be accepted (Ready high) and dropped: Wr_En=0 next cycle.
REQ-023 Clear_Req=1 in IDLE SHALL take priority over pending requests: Req_Ready=0 that cycle, and the FSM SHALL enter CLEAR on the next edge.
REQ-024 In CLEAR, Req_Ready SHALL be 0 and Clear_Busy SHALL be 1; on each of R consecutive cycles the outputs SHALL be Wr_En=1<<j, Wr_Addr=j, Wr_Data=0, for j=0..R-1 in order.
REQ-025 After the step j=R-1 has been presented, the FSM SHALL return to IDLE, with Clear_Busy=0 and request grants allowed in the first IDLE cycle.
REQ-026 Clear_Req asserted while in CLEAR SHALL be ignored; it SHALL not restart or extend the sequence.
REQ-027 A transfer accepted in the cycle before CLEAR is entered SHALL still produce its Wr_En pulse; that pulse coincides with the cycle CLEAR is entered.
REQ-028 CLEAR SHALL drive the step j=0 on the cycle after its entry cycle.
REQ-029 The pointer SHALL be unchanged by CLEAR.
REQ-030 Requests pending during CLEAR SHALL be held by the requesters and not lost.

Reset
REQ-031 While RST=0, the outputs SHALL be Wr_En=0, Wr_Data=0, Wr_Addr=0, Req_Ready=0 and Clear_Busy=0; the FSM SHALL be in IDLE and the pointer SHALL favour requester 0 on the first contention.
REQ-032 RST asserted mid-CLEAR or mid-pulse SHALL abort immediately and asynchronously to the reset state; no further Wr_En SHALL be issued.

Verification
REQ-033 Reset then Req_Valid=01, Addr0=3, Data0=8'hA5 -> Req_Ready=01 same cycle; next cycle Wr_En=8'h08, Wr_Addr=3, Wr_Data=8'hA5; the cycle after, Wr_En=0.
REQ-034 Both requesters valid continuously, Addr0=1, Addr1=2 -> grants alternate 0,1,0,1; Wr_En alternates 02,04,02,04.
REQ-035 Clear_Req=1 together with both valid -> Req_Ready=00; Clear_Busy high for 8 cycles; Wr_En=01,02,...,80 with Wr_Data=0; then IDLE grants resume with the round-robin order preserved.
REQ-036 Clear_Req pulsed again during CLEAR -> exactly 8 clear steps occur, with no restart.
REQ-037 RST dropped at clear step j=3 -> outputs zero immediately; after release, IDLE with Clear_Busy=0 and no residual Wr_En.
REQ-038 R=6 with Req_Addr0=7 -> Req_Ready[0]=1, Wr_En=0 next cycle; CLEAR runs 6 steps (01..20).
